// File: rtl/ram_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_bus_pkg
// Description : Shared types and field positions for the RAM bank bus
//               initiator (address field layout, widths, state encoding).
// Revision    : 1.0 - initial release
// ============================================================================
package ram_bus_pkg;

  localparam int BANK_MSB = 63;
  localparam int BANK_LSB = 56;
  localparam int WORD_MSB = 7;
  localparam int DATA_W   = 64;
  localparam int LEN_W    = 4;

  localparam int BANK_W   = BANK_MSB - BANK_LSB + 1;
  localparam int WORD_W   = WORD_MSB + 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

  // Bank bus address: bank in the top byte, word in the bottom byte, zeros between.
  function automatic logic [DATA_W-1:0] make_bus_addr(input logic [BANK_W-1:0] bank,
                                                      input logic [WORD_W-1:0] word);
    return {bank, {(DATA_W - BANK_W - WORD_W){1'b0}}, word};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_bus_initiator.sv
`default_nettype none
// ============================================================================
// Module      : ram_bus_initiator
// Description : Bus master for the RAM256x64 bank array. Accepts single- or
//               multi-beat read/write bursts, drives the shared bank bus and
//               returns read data / completions on a valid/ready port.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_bus_initiator
  import ram_bus_pkg::*;
#(
  parameter int NUM_BANKS = 4
) (
  input  logic              clock,
  input  logic              reset,
  // request port
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              wdata_ready,
  // response port
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_last,
  output logic              rsp_err,
  // bank bus
  output logic [DATA_W-1:0] bus_address,
  output logic [DATA_W-1:0] bus_in,
  output logic              bus_write,
  input  logic [DATA_W-1:0] bus_out
);

  // One extra bit so NUM_BANKS = 2**BANK_W still compares correctly.
  localparam logic [BANK_W:0] BANK_LIMIT = (BANK_W + 1)'(NUM_BANKS);

  state_e              state;
  state_e              state_next;
  logic [BANK_W-1:0]   bank_q;
  logic [WORD_W-1:0]   word_q;
  logic [LEN_W-1:0]    beats_left;   // beats still to drive/issue after the current one
  logic                rd_pending;   // bus_address holds a word whose data is not yet captured

  logic                accept;
  logic                capture;
  logic                rsp_take;
  logic [BANK_W-1:0]   req_bank;
  logic                req_unmapped;
  logic                unused_addr_bits;

  assign req_bank         = req_addr[BANK_MSB:BANK_LSB];
  assign req_unmapped     = ({1'b0, req_bank} >= BANK_LIMIT);
  assign accept           = req_valid && req_ready;
  assign rsp_take         = rsp_valid && rsp_ready;
  assign bus_address      = make_bus_addr(bank_q, word_q);
  assign unused_addr_bits = ^req_addr[BANK_LSB-1:WORD_MSB+1];

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (req_unmapped)   state_next = ST_ERR;
          else if (req_write) state_next = ST_WRITE;
          else                state_next = ST_READ;
        end
      end
      ST_WRITE: if (beats_left == '0) state_next = ST_DONE;
      ST_READ:  if (rsp_take && rsp_last) state_next = ST_IDLE;
      ST_DONE:  if (rsp_ready) state_next = ST_IDLE;
      ST_ERR:   if (rsp_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // State-decoded controls: request acceptance and read-capture strobe.
  always_comb begin
    req_ready = 1'b0;
    capture   = 1'b0;
    case (state)
      ST_IDLE: req_ready = !reset;
      ST_READ: capture   = rd_pending && (!rsp_valid || rsp_ready);
      default: ;
    endcase
  end

  // Datapath: address sequencing, bus drive and response registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      bank_q      <= '0;
      word_q      <= '0;
      beats_left  <= '0;
      rd_pending  <= 1'b0;
      bus_in      <= '0;
      bus_write   <= 1'b0;
      wdata_ready <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_last    <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_rdata   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept && req_unmapped) begin
            // Error completion only; bank/word registers keep the bus untouched.
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_last  <= 1'b1;
            rsp_rdata <= '0;
          end else if (accept) begin
            bank_q     <= req_bank;
            word_q     <= req_addr[WORD_MSB:0];
            beats_left <= req_len;
            if (req_write) begin
              // First beat's data comes with the request itself.
              bus_write   <= 1'b1;
              wdata_ready <= 1'b1;
              bus_in      <= req_wdata;
            end else begin
              rd_pending  <= 1'b1;
            end
          end
        end

        ST_WRITE: begin
          if (beats_left == '0) begin
            bus_write   <= 1'b0;
            wdata_ready <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_last    <= 1'b1;
            rsp_err     <= 1'b0;
            rsp_rdata   <= '0;
          end else begin
            word_q     <= word_q + WORD_W'(1);
            bus_in     <= req_wdata;
            beats_left <= beats_left - LEN_W'(1);
          end
        end

        ST_READ: begin
          if (capture) begin
            // Bank output reflects the word addressed during the cycle now ending.
            rsp_rdata <= bus_out;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_last  <= (beats_left == '0);
            if (beats_left != '0) begin
              word_q     <= word_q + WORD_W'(1);
              beats_left <= beats_left - LEN_W'(1);
            end else begin
              rd_pending <= 1'b0;
            end
          end else if (rsp_take) begin
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
          end
        end

        ST_DONE, ST_ERR: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            rsp_err   <= 1'b0;
          end
        end

        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_bus_initiator.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ram_bus_initiator
// Description : Self-checking bench for ram_bus_initiator with a negedge
//               RAM bank model and a word-level memory reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_bus_initiator;

  localparam int NB = 4;

  logic        clock     = 1'b0;
  logic        reset     = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [63:0] req_addr  = '0;
  logic [3:0]  req_len   = '0;
  logic [63:0] req_wdata = '0;
  logic        rsp_ready = 1'b0;
  logic        req_ready, wdata_ready, rsp_valid, rsp_last, rsp_err, bus_write;
  logic [63:0] rsp_rdata, bus_address, bus_in;
  wire  [63:0] bus_out;

  int tests = 0;
  int fails = 0;

  ram_bus_initiator #(.NUM_BANKS(NB)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
    .wdata_ready(wdata_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_last(rsp_last), .rsp_err(rsp_err),
    .bus_address(bus_address), .bus_in(bus_in), .bus_write(bus_write),
    .bus_out(bus_out)
  );

  always #5 clock = ~clock;

  // RAM bank array: acts on negedge, registered output, z when unselected.
  logic [63:0] bank_mem [NB][256];
  logic [63:0] bank_rd  = '0;
  logic        bank_sel = 1'b0;
  logic        mem_init = 1'b0;
  assign bus_out = bank_sel ? bank_rd : 64'bz;

  always @(negedge clock) begin
    if (!mem_init) begin
      for (int b = 0; b < NB; b++)
        for (int w = 0; w < 256; w++) bank_mem[b][w] <= '0;
      mem_init <= 1'b1;
    end else if (bus_address[63:56] < 8'(NB)) begin
      bank_sel <= 1'b1;
      bank_rd  <= bank_mem[bus_address[57:56]][bus_address[7:0]];
      if (bus_write) bank_mem[bus_address[57:56]][bus_address[7:0]] <= bus_in;
    end else begin
      bank_sel <= 1'b0;
    end
  end

  // Reference memory image: what every word should contain.
  logic [63:0] ref_mem [NB][256];
  logic [63:0] wbuf [16];

  // Results of the last read burst.
  logic [63:0] rd_data[$];
  bit          rd_last[$];
  bit          rd_err[$];
  int          rd_first, rd_end, rd_hold_viol;
  bit          rd_timeout;

  task automatic wait_idle();
    for (int k = 0; k < 50 && !req_ready; k++) @(negedge clock);
  endtask

  task automatic do_write(input logic [7:0] bank, input logic [7:0] word, input int beats,
                          output int lat, output bit tmo, output logic err,
                          output logic [63:0] rdata, output logic last);
    int idx;
    lat = 0; tmo = 1'b1; err = 1'bx; rdata = 'x; last = 1'bx;
    @(negedge clock);
    wait_idle();
    req_valid = 1'b1; req_write = 1'b1; req_addr = {bank, 48'h0, word};
    req_len = 4'(beats - 1); req_wdata = wbuf[0];
    @(negedge clock);
    req_valid = 1'b0; idx = 1;
    for (int c = 1; c <= 40; c++) begin
      if (rsp_valid) begin
        lat = c; err = rsp_err; rdata = rsp_rdata; last = rsp_last; tmo = 1'b0;
        break;
      end
      if (wdata_ready) begin
        req_wdata = (idx < 16) ? wbuf[idx] : 64'h0;
        idx++;
      end
      @(negedge clock);
    end
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
  endtask

  // mode 0: ready always high, 1: pattern 1,0,0,1 repeating, 2: random.
  task automatic do_read(input logic [7:0] bank, input logic [7:0] word, input int beats,
                         input int mode);
    bit          stalled;
    logic [63:0] held;
    rd_data.delete(); rd_last.delete(); rd_err.delete();
    rd_first = 0; rd_end = 0; rd_hold_viol = 0; rd_timeout = 1'b1;
    @(negedge clock);
    wait_idle();
    req_valid = 1'b1; req_write = 1'b0; req_addr = {bank, 48'h0, word};
    req_len = 4'(beats - 1);
    @(negedge clock);
    req_valid = 1'b0; stalled = 1'b0; held = '0;
    for (int c = 1; c <= 300; c++) begin
      if (stalled && bus_address !== held) rd_hold_viol++;
      case (mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = ((c % 4) == 1) || ((c % 4) == 0);
        default: rsp_ready = 1'($urandom_range(0, 1));
      endcase
      if (rsp_valid && rd_first == 0) rd_first = c;
      stalled = rsp_valid && !rsp_ready;
      held    = bus_address;
      if (rsp_valid && rsp_ready) begin
        rd_data.push_back(rsp_rdata);
        rd_last.push_back(rsp_last);
        rd_err.push_back(rsp_err);
        if (rsp_last) begin
          rd_end = c; rd_timeout = 1'b0;
          @(negedge clock);
          break;
        end
      end
      @(negedge clock);
    end
    rsp_ready = 1'b0;
  endtask

  // Count beats that disagree with the reference image or carry a wrong last/err flag.
  function automatic int read_mismatches(input logic [7:0] bank, input logic [7:0] word,
                                         input int beats);
    int bad = 0;
    if (rd_data.size() != beats) return beats + 1;
    for (int i = 0; i < beats; i++) begin
      if (rd_data[i] !== ref_mem[bank[1:0]][8'(word + i)]) bad++;
      if (rd_last[i] != (i == beats - 1)) bad++;
      if (rd_err[i]) bad++;
    end
    return bad;
  endfunction

  task automatic test_reset();
    @(negedge clock); @(negedge clock);
    tests++;
    if (req_ready !== 1'b0) begin fails++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
    tests++;
    if ({rsp_valid, rsp_last, rsp_err, bus_write, wdata_ready} !== 5'b0) begin
      fails++; $display("FAIL reset_flags: got %b want 00000", {rsp_valid, rsp_last, rsp_err, bus_write, wdata_ready});
    end
    tests++;
    if ({rsp_rdata, bus_address, bus_in} !== 192'h0) begin
      fails++; $display("FAIL reset_data: rdata %h addr %h bus_in %h want 0", rsp_rdata, bus_address, bus_in);
    end
    reset = 1'b0;
    @(negedge clock);
    tests++;
    if (req_ready !== 1'b1) begin fails++; $display("FAIL post_reset_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_single_write_read();
    int lat; bit tmo; logic err, last; logic [63:0] rdata;
    wbuf[0] = 64'hDEADBEEF_00000001;
    do_write(8'd1, 8'h10, 1, lat, tmo, err, rdata, last);
    ref_mem[1][8'h10] = wbuf[0];
    tests++;
    if (tmo || lat != 2) begin fails++; $display("FAIL single_write_latency: got %0d want 2 (timeout %0d)", lat, tmo); end
    tests++;
    if ({err, last} !== 2'b01 || rdata !== 64'h0) begin
      fails++; $display("FAIL single_write_rsp: err %b last %b rdata %h want 0 1 0", err, last, rdata);
    end
    do_read(8'd1, 8'h10, 1, 0);
    tests++;
    if (rd_timeout || rd_first != 2) begin fails++; $display("FAIL single_read_latency: got %0d want 2", rd_first); end
    tests++;
    if (rd_data.size() != 1 || rd_data[0] !== 64'hDEADBEEF_00000001 || !rd_last[0]) begin
      fails++; $display("FAIL single_read_data: got %h (beats %0d) want deadbeef00000001", rd_data.size() ? rd_data[0] : 64'hx, rd_data.size());
    end
  endtask

  task automatic test_burst_wrap();
    int lat, bad; bit tmo; logic err, last; logic [63:0] rdata;
    for (int i = 0; i < 4; i++) begin
      wbuf[i] = 64'(i + 1);
      ref_mem[0][8'(8'hFE + i)] = 64'(i + 1);
    end
    do_write(8'd0, 8'hFE, 4, lat, tmo, err, rdata, last);
    tests++;
    if (tmo || lat != 5) begin fails++; $display("FAIL wrap_write_latency: got %0d want 5", lat); end
    do_read(8'd0, 8'hFE, 4, 0);
    bad = 0;
    if (rd_data.size() != 4) bad = 99;
    else for (int i = 0; i < 4; i++) begin
      if (rd_data[i] !== 64'(i + 1)) bad++;
      if (rd_last[i] != (i == 3)) bad++;
    end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL wrap_read_data: %0d bad beats/flags of %0d beats, want 0", bad, rd_data.size()); end
    tests++;
    if (rd_timeout || rd_first != 2 || rd_end != 5) begin
      fails++; $display("FAIL wrap_read_timing: first %0d last %0d want 2 5", rd_first, rd_end);
    end
    tests++;
    if (bank_mem[0][1] !== 64'd4 || bank_mem[0][8'hFE] !== 64'd1) begin
      fails++; $display("FAIL wrap_bank_image: w01 %h wFE %h want 4 1", bank_mem[0][1], bank_mem[0][8'hFE]);
    end
  endtask

  task automatic test_backpressure();
    int lat, bad; bit tmo; logic err, last; logic [63:0] rdata;
    for (int i = 0; i < 8; i++) begin
      wbuf[i] = {$urandom, $urandom};
      ref_mem[3][8'(8'h80 + i)] = wbuf[i];
    end
    do_write(8'd3, 8'h80, 8, lat, tmo, err, rdata, last);
    do_read(8'd3, 8'h80, 8, 1);
    bad = read_mismatches(8'd3, 8'h80, 8);
    tests++;
    if (rd_timeout || bad != 0) begin
      fails++; $display("FAIL backpressure_data: %0d mismatches, %0d beats, want 0 and 8", bad, rd_data.size());
    end
    tests++;
    if (rd_hold_viol != 0) begin fails++; $display("FAIL backpressure_addr_hold: %0d moves while stalled, want 0", rd_hold_viol); end
  endtask

  task automatic test_unmapped();
    logic [63:0] addr_before;
    @(negedge clock);
    wait_idle();
    addr_before = bus_address;
    req_valid = 1'b1; req_write = 1'b0; req_addr = {8'd7, 48'h0, 8'h22}; req_len = 4'd3;
    @(negedge clock);
    req_valid = 1'b0;
    tests++;
    if ({rsp_valid, rsp_err, rsp_last} !== 3'b111 || rsp_rdata !== 64'h0) begin
      fails++; $display("FAIL unmapped_rsp: v/err/last %b rdata %h want 111 0", {rsp_valid, rsp_err, rsp_last}, rsp_rdata);
    end
    tests++;
    if (bus_write !== 1'b0 || bus_address !== addr_before) begin
      fails++; $display("FAIL unmapped_bus: write %b addr %h want 0 %h", bus_write, bus_address, addr_before);
    end
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      fails++; $display("FAIL unmapped_return: rsp_valid %b req_ready %b want 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid_write();
    int idx, bad;
    for (int i = 0; i < 16; i++) wbuf[i] = {$urandom, $urandom};
    @(negedge clock);
    wait_idle();
    req_valid = 1'b1; req_write = 1'b1; req_addr = {8'd2, 48'h0, 8'h40}; req_len = 4'd15;
    req_wdata = wbuf[0];
    @(negedge clock);
    req_valid = 1'b0; idx = 1;
    for (int c = 1; c <= 3; c++) begin
      if (wdata_ready) begin req_wdata = wbuf[idx]; idx++; end
      if (c < 3) @(negedge clock);
    end
    tests++;
    if (bus_write !== 1'b1 || bus_address[7:0] !== 8'h42) begin
      fails++; $display("FAIL midwrite_beat3: write %b word %h want 1 42", bus_write, bus_address[7:0]);
    end
    reset = 1'b1;
    @(negedge clock);
    tests++;
    if ({bus_write, wdata_ready, rsp_valid, req_ready} !== 4'b0) begin
      fails++; $display("FAIL midwrite_reset: write/wrdy/rsp/req %b want 0000", {bus_write, wdata_ready, rsp_valid, req_ready});
    end
    reset = 1'b0;
    @(negedge clock);
    tests++;
    if (req_ready !== 1'b1) begin fails++; $display("FAIL midwrite_ready: got %b want 1", req_ready); end
    for (int i = 0; i < 3; i++) ref_mem[2][8'(8'h40 + i)] = wbuf[i];
    bad = 0;
    for (int i = 0; i < 16; i++) if (bank_mem[2][8'(8'h40 + i)] !== ref_mem[2][8'(8'h40 + i)]) bad++;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL midwrite_image: %0d words differ, want 0", bad); end
    do_read(8'd2, 8'h40, 16, 0);
    bad = read_mismatches(8'd2, 8'h40, 16);
    tests++;
    if (rd_timeout || bad != 0) begin fails++; $display("FAIL midwrite_readback: %0d mismatches want 0", bad); end
  endtask

  task automatic test_random();
    logic [7:0] bank, word;
    int beats, lat, bad; bit tmo; logic err, last; logic [63:0] rdata;
    for (int n = 0; n < 24; n++) begin
      bank  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(4, 255)) : 8'($urandom_range(0, NB - 1));
      word  = 8'($urandom);
      beats = $urandom_range(1, 16);
      if (bank >= 8'(NB)) begin
        do_read(bank, word, beats, 2);
        tests++;
        if (rd_timeout || rd_data.size() != 1 || !rd_err[0] || !rd_last[0] || rd_data[0] !== 64'h0) begin
          fails++; $display("FAIL rand_err n=%0d: beats %0d err %0d rdata %h want 1 1 0", n, rd_data.size(),
                            rd_err.size() ? rd_err[0] : 1'b0, rd_data.size() ? rd_data[0] : 64'hx);
        end
      end else if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 16; i++) wbuf[i] = {$urandom, $urandom};
        do_write(bank, word, beats, lat, tmo, err, rdata, last);
        for (int i = 0; i < beats; i++) ref_mem[bank[1:0]][8'(word + i)] = wbuf[i];
        tests++;
        if (tmo || lat != beats + 1 || err !== 1'b0 || last !== 1'b1 || rdata !== 64'h0) begin
          fails++; $display("FAIL rand_write n=%0d: lat %0d err %b last %b want %0d 0 1", n, lat, err, last, beats + 1);
        end
      end else begin
        do_read(bank, word, beats, 2);
        bad = read_mismatches(bank, word, beats) + rd_hold_viol;
        tests++;
        if (rd_timeout || bad != 0) begin
          fails++; $display("FAIL rand_read n=%0d: %0d mismatches, %0d beats want 0 %0d", n, bad, rd_data.size(), beats);
        end
      end
    end
  endtask

  initial begin
    for (int b = 0; b < NB; b++)
      for (int w = 0; w < 256; w++) ref_mem[b][w] = '0;
    test_reset();
    test_single_write_read();
    test_burst_wrap();
    test_backpressure();
    test_unmapped();
    test_reset_mid_write();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/ram_bus_initiator.md
# ram_bus_initiator

Bus master for the RAM256x64 bank array: accepts single- or multi-beat read/write requests on a valid/ready port and drives the shared 64-bit address/data/write bus to the selected bank. It sequences word addresses, captures read data returned on the negedge-registered bank output, and returns it on a valid/ready response port. It sits between the CPU load/store path and the RAM banks, and is the only driver of the bank bus.

## Interface
- NUM_BANKS, 4: banks present; valid bank IDs are 0..NUM_BANKS-1 (address[63:56]).
- clock  in  1  system clock; all initiator logic on posedge. Banks act on negedge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when valid&ready.
- req_write  in  1  1 = write burst, 0 = read burst.
- req_addr  in  64  [63:56] bank, [7:0] start word; other bits ignored.
- req_len  in  4  beats minus one (1..16 beats).
- req_wdata  in  64  write data; sampled once per beat (see Operation).
- wdata_ready  out  1  current req_wdata beat consumed this cycle.
- rsp_valid  out  1  response beat present.
- rsp_ready  in  1  response consumed when valid&ready.
- rsp_rdata  out  64  read data; 0 for write/error responses.
- rsp_last  out  1  final beat of the burst.
- rsp_err  out  1  unmapped bank; no bus access made.
- bus_address  out  64  {bank, 48'b0, word}.
- bus_in  out  64  write data to banks.
- bus_write  out  1  write enable to banks.
- bus_out  in  64  read data from banks (z when no bank selected).

## Operation
- States: IDLE, READ, WRITE, DONE, ERR.
- IDLE: req_ready=1. On accept: latch bank, word, beats=req_len+1, write flag. bank>=NUM_BANKS -> ERR; write -> WRITE; else READ.
- WRITE: one beat per cycle; bus_write=1, bus_address=current word, bus_in=req_wdata, wdata_ready=1. Word increments mod 256 (wraps 255->0, bank unchanged). After last beat -> DONE.
- DONE: rsp_valid=1, rsp_last=1, rsp_err=0, rsp_rdata=0; hold until rsp_ready -> IDLE.
- READ: issue a beat (advance bus_address to the next word) only when the response slot is free (!rsp_valid or rsp_ready). Data from bus_out is captured into rsp_rdata at the posedge ending an issue cycle and sets rsp_valid; rsp_last is set on the final beat. When stalled, bus_address holds and no capture occurs. After the last beat is consumed -> IDLE.
- ERR: rsp_valid=1, rsp_err=1, rsp_last=1, rsp_rdata=0 until rsp_ready -> IDLE. The bus is never touched.
- bus_write=0 in every state except WRITE.
- Reset values: state IDLE; req_ready=0 during the reset cycle, then 1; rsp_valid, rsp_last, rsp_err, bus_write, wdata_ready=0; rsp_rdata, bus_address, bus_in=0.
- Reset mid-burst: bus_write drops in the same cycle and any pending response is discarded. Remaining beats are abandoned; already-written words stay written.

## Timing
- Write: accept at edge E0. Beats are driven in cycles 1..L, and the banks latch each beat at its mid-cycle negedge. DONE response in cycle L+1.
- Read: accept at E0. bus_address=A0 in cycle 1, and the bank registers mem[A0] at the negedge of cycle 1. rsp_valid with mem[A0] in cycle 2.
- Read throughput: 1 beat/cycle with rsp_ready held high; an L-beat read occupies cycles 1..L+1.
- Next request is accepted the cycle after IDLE is re-entered. There is no overlap between bursts.
- bus_address, bus_in and bus_write are posedge-registered, so they are stable across the bank's negedge sample.

## Structure
- Package ram_bus_pkg: state enum; BANK_MSB=63, BANK_LSB=56, WORD_MSB=7, DATA_W=64, LEN_W=4.
- Single module, no sub-modules. The beat counter and word counter are local registers.

## Test plan
- Single write then read: write 0xDEADBEEF_00000001 to bank 1 word 0x10, then read it -> DONE response in cycle 2; read rsp_valid in cycle 2 after accept with matching data.
- Burst wrap: 4-beat write to bank 0 starting at word 0xFE with data 1..4, then 4-beat read -> words 0xFE, 0xFF, 0x00, 0x01 return 1..4 in order; rsp_last on the 4th beat only.
- Backpressure: 8-beat read with rsp_ready toggling 1,0,0,1,... -> bus_address holds while stalled; all 8 words are returned once each, in order, with none lost or duplicated.
- Unmapped bank (NUM_BANKS=4): read at bank 7 -> rsp_err=1, rsp_rdata=0 one cycle after accept; bus_write stays 0 and bus_address is unchanged.
- Reset mid-write: assert reset during beat 3 of a 16-beat write -> bus_write=0 on the next edge; words 0-2 are written and word 3 onward unchanged; req_ready=1 after reset deasserts.
